mio_input_ctrl: RTL and testbench

//  Memory-mapped input responder on the MIO bus: synchronises and debounces board switches, latches rising

---
 rtl/mio_pkg.sv | 11 +
 rtl/mio_input_ctrl_if.sv | 14 +
 rtl/mio_debounce_bit.sv | 66 ++++++
 rtl/mio_input_ctrl.sv | 123 ++++++++++++
 tb/tb_mio_input_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mio_pkg.sv
// Shared constants for the MIO input responder: register word offsets and bus width.
package mio_pkg;

  localparam int MIO_DATA_W = 32;

  localparam logic [1:0] MIO_OFF_STATE = 2'd0;
  localparam logic [1:0] MIO_OFF_PEND  = 2'd1;
  localparam logic [1:0] MIO_OFF_MASK  = 2'd2;
  localparam logic [1:0] MIO_OFF_CNT   = 2'd3;

endpackage

// File: rtl/mio_input_ctrl_if.sv
// MIO bus slice seen by the input responder: select, write strobe, word offset, data in/out.
interface mio_input_ctrl_if;
  import mio_pkg::*;

  logic                  sel;
  logic                  we;
  logic [1:0]            addr;
  logic [MIO_DATA_W-1:0] wdata;
  logic [MIO_DATA_W-1:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/mio_debounce_bit.sv
// One input bit: 2-flop synchroniser, tick-driven sample shifter and the debounced level.
// rise pulses in the cycle whose clock edge moves level from 0 to 1.
module mio_debounce_bit #(
  parameter int DB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic                  sync1_r;
  logic                  sync2_r;
  logic [DB_SAMPLES-1:0] samp_r;
  logic                  level_r;
  logic                  level_next_s;

  // Bring the asynchronous raw input into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Shift the synchronised value into the sample history once per prescaler tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_r <= '0;
    end else if (tick) begin
      samp_r <= {samp_r[DB_SAMPLES-2:0], sync2_r};
    end else begin
      samp_r <= samp_r;
    end
  end

  // A new level is accepted only when the whole history agrees.
  always_comb begin
    level_next_s = level_r;
    if (&samp_r) begin
      level_next_s = 1'b1;
    end else if (~|samp_r) begin
      level_next_s = 1'b0;
    end else begin
      level_next_s = level_r;
    end
  end

  // Debounced level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= 1'b0;
    end else begin
      level_r <= level_next_s;
    end
  end

  assign level = level_r;
  assign rise  = level_next_s & ~level_r;

endmodule

// File: rtl/mio_input_ctrl.sv
// MIO input responder: debounced switch state, sticky rising-edge pending bits with mask,
// edge event counter and a registered level interrupt.
module mio_input_ctrl
  import mio_pkg::*;
#(
  parameter int NSW        = 16,
  parameter int DB_DIV     = 100000,
  parameter int DB_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSW-1:0]    in_i,
  mio_input_ctrl_if.slave   bus,
  output logic              irq
);

  localparam int                PRESC_W    = $clog2(DB_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DB_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [PRESC_W-1:0]    presc_r;
  logic                  tick_s;
  logic [NSW-1:0]        state_s;
  logic [NSW-1:0]        rise_s;
  logic [NSW-1:0]        pend_r;
  logic [NSW-1:0]        pend_next_s;
  logic [NSW-1:0]        mask_r;
  logic [NSW-1:0]        mask_next_s;
  logic [31:0]           cnt_r;
  logic [31:0]           cnt_next_s;
  logic                  irq_r;
  logic                  evt_s;
  logic                  wr_s;
  logic [MIO_DATA_W-1:0] rdata_s;
  logic                  unused_wdata_s;

  assign tick_s         = (presc_r == PRESC_LAST);
  assign wr_s           = bus.sel & bus.we;
  assign evt_s          = |(rise_s & mask_r);
  assign unused_wdata_s = ^bus.wdata;

  // Debounce sample prescaler: 0..DB_DIV-1, tick on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  for (genvar i = 0; i < NSW; i++) begin : g_db
    mio_debounce_bit #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_s),
      .raw   (in_i[i]),
      .level (state_s[i]),
      .rise  (rise_s[i])
    );
  end

  // Next values of PEND (set beats clear), MASK and CNT (clear then count).
  always_comb begin
    pend_next_s = pend_r;
    mask_next_s = mask_r;
    cnt_next_s  = cnt_r;
    if (wr_s && (bus.addr == MIO_OFF_PEND)) begin
      pend_next_s = pend_r & ~bus.wdata[NSW-1:0];
    end else begin
      pend_next_s = pend_r;
    end
    pend_next_s = pend_next_s | (rise_s & mask_r);
    if (wr_s && (bus.addr == MIO_OFF_MASK)) begin
      mask_next_s = bus.wdata[NSW-1:0];
    end else begin
      mask_next_s = mask_r;
    end
    if (wr_s && (bus.addr == MIO_OFF_CNT)) begin
      cnt_next_s = {31'd0, evt_s};
    end else if (evt_s) begin
      cnt_next_s = cnt_r + 32'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Software-visible registers and the interrupt, which trails PEND/MASK by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
      mask_r <= '0;
      cnt_r  <= 32'd0;
      irq_r  <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      mask_r <= mask_next_s;
      cnt_r  <= cnt_next_s;
      irq_r  <= |(pend_r & mask_r);
    end
  end

  // Read mux; zero when not selected and above NSW.
  always_comb begin
    rdata_s = '0;
    if (bus.sel) begin
      case (bus.addr)
        MIO_OFF_STATE: rdata_s[NSW-1:0] = state_s;
        MIO_OFF_PEND:  rdata_s[NSW-1:0] = pend_r;
        MIO_OFF_MASK:  rdata_s[NSW-1:0] = mask_r;
        MIO_OFF_CNT:   rdata_s          = cnt_r;
        default:       rdata_s          = '0;
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  assign bus.rdata = rdata_s;
  assign irq       = irq_r;

endmodule

// File: tb/tb_mio_input_ctrl.sv
// Bench for mio_input_ctrl: directed table and corner sequences plus random traffic,
// all checked against a queue-based behavioural model of the debounced register file.
module tb_mio_input_ctrl;
  import mio_pkg::*;

  localparam int NSW        = 16;
  localparam int DB_DIV     = 4;
  localparam int DB_SAMPLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_i = 16'h0000;
  logic        irq;

  mio_input_ctrl_if bus();

  mio_input_ctrl #(.NSW(NSW), .DB_DIV(DB_DIV), .DB_SAMPLES(DB_SAMPLES)) dut (
    .clk  (clk),
    .rst  (rst),
    .in_i (in_i),
    .bus  (bus),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: last DB_SAMPLES sampled words, input delay line, register file.
  logic [15:0] m_q[$];
  logic [15:0] m_sync1, m_sync2, m_state, m_pend, m_mask;
  logic [31:0] m_cnt;
  logic        m_irq;
  int          m_phase;

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    repeat (DB_SAMPLES) m_q.push_back(16'h0000);
    m_sync1 = 16'h0; m_sync2 = 16'h0; m_state = 16'h0;
    m_pend  = 16'h0; m_mask  = 16'h0; m_cnt   = 32'd0;
    m_irq   = 1'b0;  m_phase = 0;
  endtask

  // Level the history qualifies: bits unanimous at 1 go high, unanimous at 0 go low.
  function automatic logic [15:0] model_level();
    logic [15:0] and_w = 16'hFFFF;
    logic [15:0] or_w  = 16'h0000;
    foreach (m_q[k]) begin
      and_w &= m_q[k];
      or_w  |= m_q[k];
    end
    return (m_state | and_w) & or_w;
  endfunction

  function automatic logic [15:0] model_rise_now();
    return model_level() & ~m_state;
  endfunction

  task automatic model_step(input logic [15:0] in_w, input logic s, input logic w,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [15:0] new_state, rise, pend_n, mask_n;
    logic [31:0] cnt_n;
    logic        evt, wr;
    new_state = model_level();
    rise      = new_state & ~m_state;
    evt       = |(rise & m_mask);
    wr        = s & w;
    pend_n    = m_pend;
    if (wr && a == MIO_OFF_PEND) pend_n &= ~wd[15:0];
    pend_n |= rise & m_mask;
    mask_n = (wr && a == MIO_OFF_MASK) ? wd[15:0] : m_mask;
    if (wr && a == MIO_OFF_CNT) cnt_n = evt ? 32'd1 : 32'd0;
    else                        cnt_n = m_cnt + (evt ? 32'd1 : 32'd0);
    m_irq = |(m_pend & m_mask);
    if (m_phase == DB_DIV - 1) begin
      m_q.push_back(m_sync2);
      void'(m_q.pop_front());
    end
    m_sync2 = m_sync1;
    m_sync1 = in_w;
    m_phase = (m_phase + 1) % DB_DIV;
    m_state = new_state; m_pend = pend_n; m_mask = mask_n; m_cnt = cnt_n;
  endtask

  function automatic logic [31:0] model_rdata(input logic s, input logic [1:0] a);
    if (!s) return 32'd0;
    case (a)
      MIO_OFF_STATE: return {16'd0, m_state};
      MIO_OFF_PEND:  return {16'd0, m_pend};
      MIO_OFF_MASK:  return {16'd0, m_mask};
      default:       return m_cnt;
    endcase
  endfunction

  // One clock: inputs held across the edge, model advanced, outputs compared 1 unit later.
  task automatic cycle();
    logic [15:0] c_in;
    logic        c_sel, c_we;
    logic [1:0]  c_addr;
    logic [31:0] c_wd;
    c_in = in_i; c_sel = bus.sel; c_we = bus.we; c_addr = bus.addr; c_wd = bus.wdata;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(c_in, c_sel, c_we, c_addr, c_wd);
    #1;
    check32("rdata", bus.rdata, model_rdata(bus.sel, bus.addr));
    check32("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    bus.sel = 1'b0; bus.we = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    cycle();
    d = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] wd);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = wd;
    cycle();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  // Waits for the model to predict a rise on bit 0 and writes in exactly that cycle.
  task automatic write_on_rise0(input logic [1:0] a, input logic [31:0] wd);
    logic [15:0] rn;
    logic        hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rn = model_rise_now();
      if (rn[0]) begin
        write_reg(a, wd);
        hit = 1'b1;
        break;
      end
      idle(1);
    end
    check32("rise0_wait", {31'd0, hit}, 32'd1);
  endtask

  task automatic toggle0();
    in_i[0] = 1'b0; idle(30);
    in_i[0] = 1'b1; idle(30);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          ones;
    logic        irq_seen;

    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    model_reset();

    // Reset held with all inputs high: every register reads 0.
    in_i = 16'hFFFF;
    rst  = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.sel = 1'b1; bus.addr = 2'(a);
      cycle();
      check32("rst_read", bus.rdata, 32'd0);
      check32("rst_irq", {31'd0, irq}, 32'd0);
    end
    rst = 1'b0;
    bus.sel = 1'b1; bus.addr = MIO_OFF_STATE;
    for (int k = 0; k < 2 + 4 * 4 + 4; k++) begin
      cycle();
      if (bus.rdata == 32'h0000_FFFF) break;
    end
    check32("state_after_rst", bus.rdata, 32'h0000_FFFF);
    read_reg(MIO_OFF_PEND, d);
    check32("pend_after_rst", d, 32'd0);

    // Glitch shorter than a tick period.
    in_i = 16'h0000; idle(30);
    write_reg(MIO_OFF_MASK, 32'h0000_FFFF);
    in_i = 16'h0008; idle(3);
    in_i = 16'h0000;
    irq_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      idle(1);
      irq_seen |= irq;
    end
    check32("glitch_irq", {31'd0, irq_seen}, 32'd0);
    read_reg(MIO_OFF_STATE, d); check32("glitch_state", d, 32'd0);
    read_reg(MIO_OFF_PEND, d);  check32("glitch_pend", d, 32'd0);
    read_reg(MIO_OFF_CNT, d);   check32("glitch_cnt", d, 32'd0);

    // Register map table: write (or not), then read back.
    tbl[0] = '{1'b1, 1'b1, MIO_OFF_MASK,  32'hFFFF_1234, MIO_OFF_MASK,  32'h0000_1234};
    tbl[1] = '{1'b1, 1'b1, MIO_OFF_STATE, 32'h0000_ABCD, MIO_OFF_STATE, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b1, MIO_OFF_MASK,  32'h0000_FFFF, MIO_OFF_MASK,  32'h0000_1234};
    tbl[3] = '{1'b1, 1'b1, MIO_OFF_CNT,   32'h0000_1234, MIO_OFF_CNT,   32'h0000_0000};
    tbl[4] = '{1'b1, 1'b1, MIO_OFF_PEND,  32'hFFFF_FFFF, MIO_OFF_PEND,  32'h0000_0000};
    tbl[5] = '{1'b1, 1'b1, MIO_OFF_MASK,  32'h0000_0005, MIO_OFF_MASK,  32'h0000_0005};
    tbl[6] = '{1'b1, 1'b0, MIO_OFF_MASK,  32'h0000_0000, MIO_OFF_MASK,  32'h0000_0005};
    for (int i = 0; i < 7; i++) begin
      bus.sel = tbl[i].sel; bus.we = tbl[i].we; bus.addr = tbl[i].addr; bus.wdata = tbl[i].wdata;
      cycle();
      bus.sel = 1'b0; bus.we = 1'b0;
      read_reg(tbl[i].rd_addr, d);
      check32($sformatf("table[%0d]", i), d, tbl[i].exp);
    end

    // Three bits rise together with MASK=0x5.
    in_i = 16'h0007;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = MIO_OFF_PEND;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (bus.rdata != 32'd0) break;
    end
    check32("edge_pend", bus.rdata, 32'h5);
    check32("edge_irq_lag", {31'd0, irq}, 32'd0);
    cycle();
    check32("edge_irq_set", {31'd0, irq}, 32'd1);
    read_reg(MIO_OFF_STATE, d); check32("edge_state", d, 32'h7);
    read_reg(MIO_OFF_CNT, d);   check32("edge_cnt", d, 32'd1);
    write_reg(MIO_OFF_PEND, 32'h1);
    read_reg(MIO_OFF_PEND, d);  check32("w1c_bit0", d, 32'h4);
    check32("w1c_irq_hold", {31'd0, irq}, 32'd1);
    write_reg(MIO_OFF_PEND, 32'h4);
    read_reg(MIO_OFF_PEND, d);  check32("w1c_bit2", d, 32'h0);
    check32("w1c_irq_clr", {31'd0, irq}, 32'd0);

    // Set wins over a same-cycle W1C.
    in_i[0] = 1'b0; idle(30);
    in_i[0] = 1'b1;
    write_on_rise0(MIO_OFF_PEND, 32'h1);
    read_reg(MIO_OFF_PEND, d);  check32("set_wins", d, 32'h1);

    // Counter: five edges, clear during a sixth, then wrap.
    write_reg(MIO_OFF_CNT, 32'd0);
    read_reg(MIO_OFF_CNT, d);   check32("cnt_clear", d, 32'd0);
    repeat (5) toggle0();
    read_reg(MIO_OFF_CNT, d);   check32("cnt_five", d, 32'd5);
    in_i[0] = 1'b0; idle(30);
    in_i[0] = 1'b1;
    write_on_rise0(MIO_OFF_CNT, 32'd0);
    read_reg(MIO_OFF_CNT, d);   check32("cnt_clear_evt", d, 32'd1);
    in_i[0] = 1'b0; idle(30);
    force dut.cnt_r = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_r;
    read_reg(MIO_OFF_CNT, d);   check32("cnt_forced", d, 32'hFFFF_FFFF);
    in_i[0] = 1'b1; idle(30);
    read_reg(MIO_OFF_CNT, d);   check32("cnt_wrap", d, 32'd0);

    // Reset with two of four samples accepted, then full re-qualification.
    in_i = 16'h0000; idle(30);
    in_i = 16'hFFFF;
    ones = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      ones = 0;
      foreach (m_q[j]) if (m_q[j][0]) ones++;
      if (ones == 2) break;
    end
    check32("two_samples", 32'(ones), 32'd2);
    rst = 1'b1;
    model_reset();
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = MIO_OFF_STATE;
    #1;
    check32("state_in_rst", bus.rdata, 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      check32($sformatf("requal[%0d]", k), bus.rdata, (k < 17) ? 32'd0 : 32'h0000_FFFF);
    end

    // Random traffic against the model.
    write_reg(MIO_OFF_MASK, 32'($urandom_range(0, 65535)));
    for (int k = 0; k < 800; k++) begin
      int r;
      if ($urandom_range(0, 15) == 0) in_i ^= 16'(1 << $urandom_range(0, 15));
      r = $urandom_range(0, 9);
      bus.addr  = 2'($urandom_range(0, 3));
      bus.wdata = $urandom();
      if (r < 7)       begin bus.sel = 1'b1; bus.we = 1'b0; end
      else if (r == 7) begin bus.sel = 1'b1; bus.we = 1'b1; end
      else             begin bus.sel = 1'b0; bus.we = 1'($urandom_range(0, 1)); end
      cycle();
    end
    bus.sel = 1'b0; bus.we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
